// File: rtl/seq_normalizer_if.sv
// Request/result handshake bundle for seq_normalizer: one operand in, one normalized result out.
interface seq_normalizer_if #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SW-1:0]    out_shift;
    logic             out_zero;

    modport master (
        output in_valid, in_data, dir, out_ready,
        input  in_ready, out_valid, out_data, out_shift, out_zero
    );

    modport slave (
        input  in_valid, in_data, dir, out_ready,
        output in_ready, out_valid, out_data, out_shift, out_zero
    );
endinterface

// File: rtl/seq_normalizer.sv
// Iterative normalizer: shifts an operand one bit per cycle until its MSB (dir=0)
// or LSB (dir=1) is set, reporting the shift count; a zero operand completes at once.
module seq_normalizer #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_normalizer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             zero_q, zero_d;
    // Holds in_ready low until the first clock edge after reset release.
    logic             arm_q;
    logic             target_bit;

    assign target_bit = dir_q ? data_q[0] : data_q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            arm_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && arm_q) begin
                    data_d  = bus.in_data;
                    dir_d   = bus.dir;
                    cnt_d   = '0;
                    zero_d  = (bus.in_data == '0);
                    state_d = (bus.in_data == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (target_bit) begin
                    state_d = DONE;
                end else begin
                    data_d = dir_q ? (data_q >> 1) : (data_q << 1);
                    cnt_d  = cnt_q + SW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) && arm_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = data_q;
    assign bus.out_shift = cnt_q;
    assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_seq_normalizer.sv
// Randomized bench for seq_normalizer against a leading/trailing-zero-count reference model.
module tb_seq_normalizer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    seq_normalizer_if #(.WIDTH(8), .SW(3)) bus();

    seq_normalizer #(.WIDTH(8), .SW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count zeros from the target end, shift by that many.
    function automatic void model(input logic [7:0] d, input logic dr,
                                  output logic [7:0] ed, output logic [2:0] es,
                                  output logic ez);
        int k;
        k = 0;
        if (d == 8'h00) begin
            ed = 8'h00; es = 3'd0; ez = 1'b1;
        end else begin
            if (dr == 1'b0) begin
                while (d[7-k] == 1'b0) k++;
                ed = d << k;
            end else begin
                while (d[k] == 1'b0) k++;
                ed = d >> k;
            end
            es = 3'(k);
            ez = 1'b0;
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 8'h00 || bus.out_shift !== 3'd0 || bus.out_zero !== 1'b0) begin
            failures++;
            $display("FAIL rst_outputs got data=%h shift=%0d zero=%b exp 00/0/0", bus.out_data, bus.out_shift, bus.out_zero);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic run_op(input logic [7:0] d, input logic dr, input int hold,
                          output logic [7:0] od, output logic [2:0] os,
                          output logic oz, output int lat);
        logic [7:0] ed, rt;
        logic [2:0] es;
        logic       ez;
        int         elat, w;
        model(d, dr, ed, es, ez);
        elat = ez ? 1 : int'(es) + 2;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin tick(); w++; end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL wait_in_ready got=%b exp=1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_data = d; bus.dir = dr;
        tick();
        bus.in_valid = 1'b0; bus.in_data = 8'($urandom); bus.dir = 1'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%b exp=0", bus.in_ready); end
            bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom); bus.out_ready = 1'($urandom);
            tick();
            lat++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        od = bus.out_data; os = bus.out_shift; oz = bus.out_zero;
        checks++;
        if (lat != elat) begin failures++; $display("FAIL latency d=%h dir=%b got=%0d exp=%0d", d, dr, lat, elat); end
        if (bus.out_valid !== 1'b1) begin
            $display("FAIL timeout d=%h dir=%b out_valid=%b exp=1", d, dr, bus.out_valid);
            do_reset();
            return;
        end
        checks++;
        if (od !== ed) begin failures++; $display("FAIL out_data d=%h dir=%b got=%h exp=%h", d, dr, od, ed); end
        checks++;
        if (os !== es) begin failures++; $display("FAIL out_shift d=%h dir=%b got=%0d exp=%0d", d, dr, os, es); end
        checks++;
        if (oz !== ez) begin failures++; $display("FAIL out_zero d=%h got=%b exp=%b", d, oz, ez); end
        if (!ez) begin
            rt = dr ? (od << os) : (od >> os);
            checks++;
            if (rt !== d) begin failures++; $display("FAIL roundtrip d=%h dir=%b got=%h exp=%h", d, dr, rt, d); end
        end
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom); bus.dir = 1'($urandom);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== od ||
                bus.out_shift !== os || bus.out_zero !== oz) begin
                failures++;
                $display("FAIL hold_stable got v=%b r=%b d=%h s=%0d z=%b exp v=1 r=0 d=%h s=%0d z=%b",
                         bus.out_valid, bus.in_ready, bus.out_data, bus.out_shift, bus.out_zero, od, os, oz);
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake_idle got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_left_full();
        logic [7:0] od; logic [2:0] os; logic oz; int lat;
        run_op(8'h01, 1'b0, 0, od, os, oz, lat);
        checks++;
        if (lat != 9 || od !== 8'h80 || os !== 3'd7 || oz !== 1'b0) begin
            failures++; $display("FAIL left_0x01 got lat=%0d d=%h s=%0d z=%b exp 9/80/7/0", lat, od, os, oz);
        end
    endtask

    task automatic test_msb_and_right();
        logic [7:0] od; logic [2:0] os; logic oz; int lat;
        run_op(8'h80, 1'b0, 0, od, os, oz, lat);
        checks++;
        if (lat != 2 || od !== 8'h80 || os !== 3'd0) begin
            failures++; $display("FAIL left_0x80 got lat=%0d d=%h s=%0d exp 2/80/0", lat, od, os);
        end
        run_op(8'h30, 1'b1, 0, od, os, oz, lat);
        checks++;
        if (lat != 6 || od !== 8'h03 || os !== 3'd4) begin
            failures++; $display("FAIL right_0x30 got lat=%0d d=%h s=%0d exp 6/03/4", lat, od, os);
        end
    endtask

    task automatic test_zero();
        logic [7:0] od; logic [2:0] os; logic oz; int lat;
        run_op(8'h00, 1'($urandom), 0, od, os, oz, lat);
        checks++;
        if (lat != 1 || od !== 8'h00 || os !== 3'd0 || oz !== 1'b1) begin
            failures++; $display("FAIL zero got lat=%0d d=%h s=%0d z=%b exp 1/00/0/1", lat, od, os, oz);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] od; logic [2:0] os; logic oz; int lat;
        run_op(8'h05, 1'b0, 5, od, os, oz, lat);
        checks++;
        if (od !== 8'hA0 || os !== 3'd5) begin
            failures++; $display("FAIL backpressure got d=%h s=%0d exp a0/5", od, os);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] od; logic [2:0] os; logic oz; int lat;
        bus.in_valid = 1'b1; bus.in_data = 8'h01; bus.dir = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_data !== 8'h00 || bus.out_shift !== 3'd0) begin
            failures++;
            $display("FAIL mid_shift_reset got v=%b r=%b d=%h s=%0d exp 0/0/00/0", bus.out_valid, bus.in_ready, bus.out_data, bus.out_shift);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_shift_ready got=%b exp=1", bus.in_ready); end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stale_result cycle=%0d got=%b exp=0", i, bus.out_valid); end
        end
        run_op(8'h10, 1'b0, 0, od, os, oz, lat);
        checks++;
        if (os !== 3'd3 || od !== 8'h80) begin
            failures++; $display("FAIL after_reset_0x10 got d=%h s=%0d exp 80/3", od, os);
        end
    endtask

    task automatic test_reset_in_done();
        bus.in_valid = 1'b1; bus.in_data = 8'h00; bus.dir = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL done_before_reset got=%b exp=1", bus.out_valid); end
        #2;
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL done_after_reset got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] od; logic [2:0] os; logic oz; int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(8'(1 << i), 1'(i % 2), 0, od, os, oz, lat);
        end
    endtask

    task automatic test_random_sweep();
        logic [7:0] od, v, d; logic [2:0] os; logic oz; int lat, sh; logic dr;
        for (int i = 0; i < 1000; i++) begin
            v  = 8'($urandom_range(0, 255));
            sh = $urandom_range(0, 7);
            dr = 1'($urandom);
            d  = dr ? (v << sh) : (v >> sh);
            run_op(d, dr, $urandom_range(0, 3), od, os, oz, lat);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.dir = 1'b0; bus.out_ready = 1'b0;
        #2;
        test_reset();
        test_left_full();
        test_msb_and_right();
        test_zero();
        test_backpressure();
        test_reset_mid_shift();
        test_reset_in_done();
        test_back_to_back();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
